mem_io: RTL and testbench
=========================

MEM_IO -- requirements
Module: mem_io

Interface
REQ-001 Parameter MEM_WORDS, default 1024, number of 32-bit RAM words (power of 2).
REQ-002 Parameter FIFO_DEPTH, default 4, TX FIFO entries (power of 2, >=2).
REQ-003 Parameter IO_BASE, default 32'hFFFF_0000, base of the memory-mapped I/O window (upper 16 bits decoded).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 ia  in  32  instruction fetch byte address from the CPU.
REQ-008 id  out  32  instruction word at ia.
REQ-009 memAddr  in  32  data byte address.
REQ-010 memWriteData  in  32  store data.
REQ-011 MemRead  in  1  load strobe.
REQ-012 MemWrite  in  1  store strobe.
REQ-013 memReadData  out  32  load data.
REQ-014 irq  out  1  timer interrupt request to the CPU.
REQ-015 tx_data  out  8  console byte at FIFO head.
REQ-016 tx_valid  out  1  FIFO non-empty.
REQ-017 tx_ready  in  1  console accepts tx_data when tx_valid & tx_ready.

Function
REQ-018 RAM index = address[log2(MEM_WORDS)+1:2]; ia[31] (supervisor bit) and all other upper bits ignored for fetch; address[1:0] ignored.
REQ-019 Data access is I/O when memAddr[31:16]==IO_BASE[31:16], else RAM; fetch always RAM.
REQ-020 id and memReadData combinational (zero latency); memReadData = 0 when MemRead low.
REQ-021 RAM write on rising edge when MemWrite & RAM-decoded; read of same word in that cycle returns old data (both ports).
REQ-022 I/O offsets (memAddr[7:0]): 0x00 COUNT rw, 0x04 CMP rw, 0x08 CTRL rw (bit0 EN, bit1 IRQ_EN, bit2 RELOAD), 0x0C STATUS, 0x10 TXDATA wo; other offsets read 0, writes ignored.
REQ-023 STATUS read: bit0 PEND, bit1 FULL, bit2 EMPTY, bit3 OVF, bits[7:4] FIFO occupancy, rest 0; writing 1 to bit0/bit3 clears it, other bits read-only.
REQ-024 When EN: COUNT==CMP -> PEND set next edge and COUNT becomes 0 if RELOAD else COUNT+1; otherwise COUNT+1, wrapping 32'hFFFF_FFFF -> 0.
REQ-025 CPU write to COUNT overrides increment/reload in the same cycle.
REQ-026 Match and W1C of PEND in the same cycle: PEND remains set.
REQ-027 irq = PEND & IRQ_EN, driven only from registers (no combinational input path).
REQ-028 Write to TXDATA pushes memWriteData[7:0]; push when full and no pop that cycle is dropped and sets OVF.
REQ-029 Pop when tx_valid & tx_ready; simultaneous push and pop when full: both occur, occupancy unchanged; push and pop when empty: push only (no bypass).
REQ-030 tx_data = head entry, stable while tx_valid & !tx_ready; read of TXDATA returns 0.

Reset
REQ-031 On reset: COUNT 0, CMP 32'hFFFF_FFFF, CTRL 0, PEND 0, OVF 0, FIFO empty, tx_valid 0, irq 0.
REQ-032 RAM contents not affected by reset; reset asserted mid-stream flushes FIFO, drops in-flight push.

Structure
REQ-033 Shared package holds IO register offsets, CTRL/STATUS bit positions, IO_BASE default.
REQ-034 FIFO implemented as sub-module tx_fifo (push, pop, full, empty, count, head); timer and decode in mem_io.

Verification
REQ-035 Store 32'hDEADBEEF to 0x40, load 0x40 next cycle -> memReadData 32'hDEADBEEF; fetch ia=32'h8000_0040 -> id 32'hDEADBEEF.
REQ-036 CMP=5, CTRL=3 from COUNT=0 -> PEND and irq high after the 6th enabled edge; W1C STATUS=1 -> irq low next cycle.
REQ-037 CMP=3, CTRL=7 -> COUNT sequence 0,1,2,3,0,1; PEND set once per wrap.
REQ-038 tx_ready=0, push 5 bytes 0x41..0x45 -> STATUS FULL=1, OVF=1, occupancy 4; tx_ready=1 -> outputs 0x41..0x44 in order, then tx_valid 0.
REQ-039 FIFO full, push 0x55 with pop same cycle -> no OVF, 0x55 emerges last; reset mid-drain -> tx_valid 0, irq 0 next cycle.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants for mem_io: I/O window base, register offsets and
// CTRL/STATUS bit positions.
package mem_io_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

    localparam logic [7:0] OFF_COUNT  = 8'h00;
    localparam logic [7:0] OFF_CMP    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_TXDATA = 8'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_RELOAD = 2;
    localparam int CTRL_W      = 3;

    localparam int ST_PEND    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_OCC_LSB = 4;

endpackage

// File: rtl/mem_io_tx_fifo.sv
// Console transmit FIFO: push/pop with head exposed, no empty bypass.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [W-1:0]  head_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/mem_io.sv
// Unified RAM with fetch and data ports, plus a memory-mapped timer and
// console transmit FIFO in the I/O window.
module mem_io
    import mem_io_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ia,
    output logic [31:0] id,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] memReadData,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [MEM_WORDS];
    logic [31:0]       count_q, count_d, cmp_q, cmp_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              pend_q, pend_d, ovf_q, ovf_d;

    logic              is_io, io_wr, match;
    logic [7:0]        off;
    logic [31:0]       io_rdata, status;
    logic              fifo_push, fifo_full, fifo_empty, push_drop;
    logic [FCW-1:0]    fifo_cnt;
    logic              unused_bits;

    assign is_io = (memAddr[31:16] == IO_BASE[31:16]);
    assign off   = memAddr[7:0];
    assign io_wr = MemWrite & is_io;
    assign match = (count_q == cmp_q);

    // Only the word-index bits of either address reach the RAM.
    assign unused_bits = ^{ia, memAddr};

    assign id = ram_q[ia[AW+1:2]];

    always_ff @(posedge clk) begin
        if (MemWrite && !is_io) ram_q[memAddr[AW+1:2]] <= memWriteData;
    end

    always_comb begin
        status                         = '0;
        status[ST_PEND]                = pend_q;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_OVF]                 = ovf_q;
        status[ST_OCC_LSB+3:ST_OCC_LSB] = 4'(fifo_cnt);
    end

    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_COUNT:  io_rdata = count_q;
            OFF_CMP:    io_rdata = cmp_q;
            OFF_CTRL:   io_rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            OFF_STATUS: io_rdata = status;
            default:    io_rdata = '0;
        endcase
    end

    assign memReadData = !MemRead ? 32'h0 : (is_io ? io_rdata : ram_q[memAddr[AW+1:2]]);

    assign fifo_push = io_wr && (off == OFF_TXDATA);
    assign push_drop = fifo_push & fifo_full & ~tx_ready;

    // CPU writes land after the timer update so they win; a match wins over W1C.
    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        if (ctrl_q[CTRL_EN]) begin
            count_d = (match && ctrl_q[CTRL_RELOAD]) ? 32'h0 : count_q + 32'd1;
        end
        if (io_wr) begin
            case (off)
                OFF_COUNT:  count_d = memWriteData;
                OFF_CMP:    cmp_d   = memWriteData;
                OFF_CTRL:   ctrl_d  = memWriteData[CTRL_W-1:0];
                OFF_STATUS: begin
                    if (memWriteData[ST_PEND]) pend_d = 1'b0;
                    if (memWriteData[ST_OVF])  ovf_d  = 1'b0;
                end
                default: ;
            endcase
        end
        if (ctrl_q[CTRL_EN] && match) pend_d = 1'b1;
        if (push_drop)                ovf_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'h0;
            cmp_q   <= 32'hFFFF_FFFF;
            ctrl_q  <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign irq      = pend_q & ctrl_q[CTRL_IRQ_EN];
    assign tx_valid = ~fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (memWriteData[7:0]),
        .pop_i   (tx_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt),
        .head_o  (tx_data)
    );

endmodule

// File: tb/tb_mem_io.sv
// Self-checking bench for mem_io: RAM ports, timer, and a scoreboarded TX FIFO.
module tb_mem_io;

    localparam logic [31:0] A_COUNT = 32'hFFFF_0000;
    localparam logic [31:0] A_CMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT  = 32'hFFFF_000C;
    localparam logic [31:0] A_TX    = 32'hFFFF_0010;
    localparam int          DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ia = '0;
    logic [31:0] id;
    logic [31:0] memAddr = '0;
    logic [31:0] memWriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] memReadData;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sbq [$];
    logic        exp_ovf = 1'b0;
    logic [31:0] rv;

    mem_io dut (
        .clk          (clk),
        .reset        (reset),
        .ia           (ia),
        .id           (id),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .memReadData  (memReadData),
        .irq          (irq),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memAddr      = a;
        memWriteData = d;
        MemWrite     = 1'b1;
        @(posedge clk); #1;
        MemWrite     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memAddr = a;
        MemRead = 1'b1;
        #1;
        d       = memReadData;
        MemRead = 1'b0;
    endtask

    // Expected bytes enter the scoreboard only when the push will really be accepted.
    task automatic push(input logic [7:0] b);
        if (sbq.size() < DEPTH || (tx_valid && tx_ready)) sbq.push_back(b);
        else exp_ovf = 1'b1;
        wr(A_TX, {24'h0, b});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sbq.size() == 0) chk("tx_spurious", {31'h0, tx_valid}, 32'h0);
            else chk("tx_data", {24'h0, tx_data}, {24'h0, sbq.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        rd(A_COUNT, rv); chk("rst_count", rv, 32'h0);
        rd(A_CMP, rv);   chk("rst_cmp", rv, 32'hFFFF_FFFF);
        rd(A_CTRL, rv);  chk("rst_ctrl", rv, 32'h0);
        rd(A_STAT, rv);  chk("rst_status", rv, 32'h4);
        chk("rst_txvalid", {31'h0, tx_valid}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;

        // RAM store/load and fetch
        wr(32'h40, 32'hDEAD_BEEF);
        rd(32'h40, rv); chk("ram_load", rv, 32'hDEAD_BEEF);
        ia = 32'h8000_0040; #1;
        chk("fetch_sup", id, 32'hDEAD_BEEF);
        rd(32'h0000_1040, rv); chk("ram_alias", rv, 32'hDEAD_BEEF);
        memAddr = 32'h40; #1;
        chk("rd_low_zero", memReadData, 32'h0);
        rd(32'hFFFF_0020, rv); chk("io_unmapped", rv, 32'h0);
        wr(32'h44, 32'h1111_1111);
        memAddr = 32'h44; memWriteData = 32'h2222_2222; MemWrite = 1'b1; MemRead = 1'b1; ia = 32'h44;
        #1;
        chk("rdw_old_data", memReadData, 32'h1111_1111);
        chk("rdw_old_fetch", id, 32'h1111_1111);
        @(posedge clk); #1;
        MemWrite = 1'b0;
        chk("rdw_new_data", memReadData, 32'h2222_2222);
        MemRead = 1'b0;

        // timer match and W1C
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'd3);
        repeat (5) @(posedge clk); #1;
        rd(A_COUNT, rv); chk("tmr_count5", rv, 32'd5);
        chk("tmr_irq_pre", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("tmr_irq_set", {31'h0, irq}, 32'h1);
        rd(A_STAT, rv); chk("tmr_status_pend", rv, 32'h5);
        wr(A_STAT, 32'h1);
        chk("tmr_irq_clr", {31'h0, irq}, 32'h0);
        wr(A_CTRL, 32'h0);

        // CPU write overrides increment, then wrap
        wr(A_CTRL, 32'h1);
        wr(A_COUNT, 32'd100);
        rd(A_COUNT, rv); chk("cnt_override", rv, 32'd100);
        @(posedge clk); #1;
        rd(A_COUNT, rv); chk("cnt_inc", rv, 32'd101);
        wr(A_COUNT, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd(A_COUNT, rv); chk("cnt_wrap", rv, 32'h0);
        wr(A_CTRL, 32'h0);

        // reload sequence
        wr(A_COUNT, 32'h0);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'd7);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] seq [6];
            seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
            rd(A_COUNT, rv); chk($sformatf("reload_cnt%0d", i), rv, seq[i]);
            rd(A_STAT, rv);  chk($sformatf("reload_pend%0d", i), rv & 32'h1, (i >= 4) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        wr(A_STAT, 32'h1);
        rd(A_STAT, rv); chk("reload_w1c", rv & 32'h1, 32'h0);
        @(posedge clk); #1;
        rd(A_STAT, rv); chk("reload_pend_again", rv & 32'h1, 32'h1);
        wr(A_CTRL, 32'h0);
        chk("irq_gated", {31'h0, irq}, 32'h0);
        wr(A_STAT, 32'h1);

        // match and W1C in the same cycle keeps PEND
        wr(A_COUNT, 32'h0);
        wr(A_CTRL, 32'd7);
        repeat (3) @(posedge clk); #1;
        wr(A_STAT, 32'h1);
        rd(A_STAT, rv); chk("w1c_vs_match", rv & 32'h1, 32'h1);
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        rd(A_STAT, rv); chk("pend_cleared", rv & 32'h1, 32'h0);

        // FIFO overflow then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
        rd(A_STAT, rv); chk("fifo_full_status", rv, {24'h0, 4'd4, exp_ovf, 3'b010});
        chk("tx_head", {24'h0, tx_data}, 32'h41);
        @(posedge clk); #1;
        chk("tx_head_stable", {24'h0, tx_data}, 32'h41);
        rd(A_TX, rv); chk("txdata_rd_zero", rv, 32'h0);
        tx_ready = 1'b1;
        wait_drain();
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);
        rd(A_STAT, rv); chk("drained_status", rv, 32'h0C);
        wr(A_STAT, 32'h8);
        exp_ovf = 1'b0;
        rd(A_STAT, rv); chk("ovf_w1c", rv, 32'h04);

        // arm timer irq, then full FIFO push with simultaneous pop
        wr(A_COUNT, 32'h0);
        wr(A_CMP, 32'h0);
        wr(A_CTRL, 32'd3);
        @(posedge clk); #1;
        chk("irq_armed", {31'h0, irq}, 32'h1);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
        tx_ready = 1'b1;
        push(8'h55);
        tx_ready = 1'b0;
        rd(A_STAT, rv); chk("push_pop_full", rv, {24'h0, 4'd4, exp_ovf, 3'b011});
        tx_ready = 1'b1;
        wait_drain();
        chk("drain2_valid", {31'h0, tx_valid}, 32'h0);

        // reset mid-drain with an in-flight push
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h71 + 8'(i));
        tx_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        memAddr = A_TX; memWriteData = 32'h77; MemWrite = 1'b1;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        reset = 1'b0;
        sbq.delete();
        chk("rst_mid_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_mid_irq", {31'h0, irq}, 32'h0);
        rd(A_STAT, rv); chk("rst_mid_status", rv, 32'h04);
        @(posedge clk); #1;
        chk("rst_mid_valid2", {31'h0, tx_valid}, 32'h0);
        rd(32'h40, rv); chk("ram_survives_rst", rv, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
